ce_gen_bank: RTL



---
 rtl/ce_gen_bank.sv | 72 +++++++
 1 files changed

// File: rtl/ce_gen_bank.sv
// Bank of independent clock-enable generators for the clk_sys domain.
// Each channel divides clk_sys by (div_active+1) and can also emit a mid-period enable.
module ce_gen_bank #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 4,
    parameter int DIV_RST  = 5
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [CHANNELS*CNT_W-1:0] div,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      resync,
    output logic [CHANNELS-1:0]       ce,
    output logic [CHANNELS-1:0]       ce_mid,
    output logic [CHANNELS*CNT_W-1:0] div_active,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
    localparam logic [CNT_W:0]   ONE_EXT   = (CNT_W+1)'(1);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] div_req;
        logic [CNT_W-1:0] div_cur;
        logic [CNT_W:0]   half;
        logic             ce_q;
        logic             mid_q;
        logic             wrap;
        logic             mid_hit;

        assign div_req = div[k*CNT_W +: CNT_W];

        // One extra bit keeps D+1 exact when D is all ones.
        assign half    = ({1'b0, div_cur} + ONE_EXT) >> 1;
        assign wrap    = (count == div_cur);
        assign mid_hit = (div_cur != '0) && ({1'b0, count} == half);

        // NOTE: state registers use non-blocking assignments so every channel
        // samples the values from before the edge, independent of statement order.
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                count   <= '0;
                ce_q    <= 1'b0;
                mid_q   <= 1'b0;
                div_cur <= DIV_RST_V;
            end else if (resync || !en[k]) begin
                count   <= '0;
                ce_q    <= 1'b0;
                mid_q   <= 1'b0;
                div_cur <= div_req;
            end else begin
                mid_q <= mid_hit;
                if (wrap) begin
                    // The requested ratio is only adopted here, so a period is never cut short.
                    count   <= '0;
                    ce_q    <= 1'b1;
                    div_cur <= div_req;
                end else begin
                    count <= count + 1'b1;
                    ce_q  <= 1'b0;
                end
            end
        end

        assign ce[k]                          = ce_q;
        assign ce_mid[k]                      = mid_q;
        assign div_active[k*CNT_W +: CNT_W]   = div_cur;
        assign pending[k]                     = en[k] && (div_req != div_cur);
    end

endmodule
